// File: rtl/mem_bus_if.sv
// mem_bus_if
//   Data-memory bus interface for the five-stage RISC-V pipeline. Turns the
//   MEM stage load/store request into a single-outstanding valid/ready
//   transaction, stalls the pipeline until the access completes and returns
//   aligned, sign/zero-extended load data.
//
//   Optional feature: define MEM_BUS_TIMEOUT_EN to compile in the WAIT-state
//   timeout counter and bus_err generation. Without it WAIT exits only on
//   bus_ack, bus_err is tied low and TIMEOUT is unused.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req_read/req_write MEM-stage load/store request (write wins if both)
//   req_addr           byte address
//   req_wdata          store data in the low bits
//   req_funct3         RISC-V funct3 (size / signedness)
//   mem_stall          combinational pipeline hold
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata          extended load data, held until the next completion
//   misalign           one-cycle pulse for a rejected misaligned access
//   bus_err            one-cycle pulse with rsp_valid on a timed-out access
//   bus_valid/ready    request handshake (bus_valid registered)
//   bus_we, bus_addr   write flag, word-aligned address
//   bus_wdata, bus_be  lane-replicated store data, byte enables
//   bus_ack, bus_rdata completion strobe and read data
module mem_bus_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        mem_stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  // Request decode
  logic        req_any;
  logic        size_byte;
  logic        size_half;
  logic        misaligned;
  logic        new_req;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  // Load extraction
  logic [15:0] sh;
  logic [31:0] ext;

  // Store and load size tables differ: funct3 4/5 are LBU/LHU for loads but
  // fall into the "treat as word" bucket for stores.
  always_comb begin
    req_any = req_read | req_write;
    if (req_write) begin
      size_byte = (req_funct3 == 3'd0);
      size_half = (req_funct3 == 3'd1);
    end else begin
      size_byte = (req_funct3 == 3'd0) || (req_funct3 == 3'd4);
      size_half = (req_funct3 == 3'd1) || (req_funct3 == 3'd5);
    end

    if (size_byte) begin
      misaligned = 1'b0;
    end else if (size_half) begin
      misaligned = req_addr[0];
    end else begin
      misaligned = (req_addr[1:0] != 2'b00);
    end

    new_req = req_any && (state_q == S_IDLE) && !misaligned;

    if (size_byte) begin
      be_new = 4'b0001 << req_addr[1:0];
    end else if (size_half) begin
      be_new = 4'b0011 << req_addr[1:0];
    end else begin
      be_new = 4'hF;
    end

    if (!req_write) begin
      wdata_new = '0;
    end else if (size_byte) begin
      wdata_new = {4{req_wdata[7:0]}};
    end else if (size_half) begin
      wdata_new = {2{req_wdata[15:0]}};
    end else begin
      wdata_new = req_wdata;
    end
  end

  always_comb begin
    sh = 16'(bus_rdata >> {lane_q, 3'b000});
    case (f3_q)
      3'd0:    ext = {{24{sh[7]}}, sh[7:0]};
      3'd1:    ext = {{16{sh[15]}}, sh};
      3'd4:    ext = {24'd0, sh[7:0]};
      3'd5:    ext = {16'd0, sh};
      default: ext = bus_rdata;
    endcase
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    misalign_d  = req_any && (state_q == S_IDLE) && misaligned;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (new_req) begin
          state_d = S_REQ;
          valid_d = 1'b1;
          we_d    = req_write;
          addr_d  = {req_addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = req_funct3;
          lane_d  = req_addr[1:0];
        end
      end
      S_REQ: begin
        // bus_valid is always high here, so bus_ready alone completes the handshake.
        if (bus_ready) begin
          state_d = S_WAIT;
          valid_d = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? '0 : ext;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_DONE: begin
        // Request inputs are still asserted here; returning to IDLE without
        // looking at them keeps the access from being issued twice.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign mem_stall = new_req | (state_q == S_REQ) | (state_q == S_WAIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign misalign  = misalign_q;
  assign bus_valid = valid_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;

endmodule

// File: tb/tb_mem_bus_if.sv
`timescale 1ns/1ps
module tb_mem_bus_if;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_stall, rsp_valid, misalign, bus_err;
  logic [31:0] rsp_rdata;
  logic        bus_valid, bus_ready, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  mem_bus_if #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_stall(mem_stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misalign(misalign), .bus_err(bus_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit          mis;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_be;
    bit          chk_wdata;
  } breq_t;

  rsp_t        exp_rsp[$];
  breq_t       exp_bus[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_hold = '0;

  int          cfg_rdy_dly = 0;
  int          cfg_ack_dly = 0;
  bit          cfg_spur = 0;
  bit          cfg_stale = 0;
  logic [31:0] cfg_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes from the RISC-V funct3 tables.
  function automatic int unsigned acc_bytes(input bit wr, input logic [2:0] f3);
    if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int unsigned off,
                                           input logic [31:0] rd);
    int unsigned n;
    bit          sgn;
    longint      v;
    longint      span;
    n   = acc_bytes(1'b0, f3);
    sgn = (f3 == 3'd0) || (f3 == 3'd1);
    if (n == 4) return rd;
    span = longint'(1) << (8 * n);
    v = (longint'(rd) / (longint'(1) << (8 * off))) % span;
    if (sgn && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Bus slave: programmable ready/ack delays, optional spurious ack in REQ
  // and a one-shot stale ack while idle.
  initial begin : responder
    int cnt;
    bit ph;
    cnt = 0;
    ph = 0;
    bus_ready = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ready = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (!rst || rsp_valid) begin
        ph = 0;
        cnt = 0;
      end else if (!ph) begin
        if (bus_valid) begin
          if (cnt < cfg_rdy_dly) begin
            cnt++;
            bus_ack = cfg_spur;
          end else begin
            bus_ready = 1'b1;
            ph = 1;
            cnt = 0;
          end
        end else if (cfg_stale) begin
          bus_ack = 1'b1;
          cfg_stale = 0;
        end
      end else begin
        if (cnt < cfg_ack_dly) begin
          cnt++;
        end else begin
          bus_ack = 1'b1;
          bus_rdata = cfg_rdata;
          ph = 0;
          cnt = 0;
        end
      end
    end
  end

  // Monitor: compares bus requests and responses against the scoreboard.
  breq_t mb;
  rsp_t  mr;
  always @(negedge clk) begin
    if (rst) begin
      if (bus_valid) begin
        if (exp_bus.size() == 0) begin
          check("bus_valid_unexpected", {31'd0, bus_valid}, 32'd0);
        end else begin
          mb = exp_bus[0];
          check("bus_addr", bus_addr, mb.addr);
          check("bus_we", {31'd0, bus_we}, {31'd0, mb.we});
          if (mb.chk_be) check("bus_be", {28'd0, bus_be}, {28'd0, mb.be});
          if (mb.chk_wdata) check("bus_wdata", bus_wdata, mb.wdata);
          if (bus_ready) void'(exp_bus.pop_front());
        end
      end
      if (rsp_valid || misalign) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", {30'd0, rsp_valid, misalign}, 32'd0);
        end else begin
          mr = exp_rsp.pop_front();
          check("misalign", {31'd0, misalign}, {31'd0, mr.mis});
          check("rsp_valid", {31'd0, rsp_valid}, {31'd0, !mr.mis});
          check("bus_err", {31'd0, bus_err}, {31'd0, mr.err});
          if (!mr.mis) exp_hold = mr.rdata;
          check("rsp_rdata", rsp_rdata, exp_hold);
        end
      end else begin
        check("rsp_rdata_hold", rsp_rdata, exp_hold);
        check("bus_err_idle", {31'd0, bus_err}, 32'd0);
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int rdy, input int ack,
                        input bit spur);
    int unsigned n;
    int unsigned off;
    bit          mis;
    bit          to;
    int          exp_st;
    int          st;
    rsp_t        r;
    breq_t       b;
    n   = acc_bytes(wr, f3);
    off = addr % 4;
    mis = (addr % n) != 0;
    to  = 0;
`ifdef MEM_BUS_TIMEOUT_EN
    to  = (ack >= int'(TB_TIMEOUT));
`endif
    st  = 0;
    @(posedge clk);
    #1;
    cfg_rdy_dly = rdy;
    cfg_ack_dly = ack;
    cfg_spur    = spur;
    cfg_rdata   = rdata;
    req_read    = rd;
    req_write   = wr;
    req_funct3  = f3;
    req_addr    = addr;
    req_wdata   = wdata;
    r.mis = mis;
    r.err = 0;
    r.rdata = '0;
    if (mis) begin
      exp_st = 0;
    end else begin
      b.addr = addr & 32'hFFFF_FFFC;
      b.we   = wr;
      b.be   = 4'(((1 << n) - 1) << off);
      if (n == 1)      b.wdata = {24'd0, wdata[7:0]} * 32'h0101_0101;
      else if (n == 2) b.wdata = {16'd0, wdata[15:0]} * 32'h0001_0001;
      else             b.wdata = wdata;
      b.chk_be    = wr || (n == 4);
      b.chk_wdata = wr;
      exp_bus.push_back(b);
      if (to) begin
        r.err  = 1;
        r.rdata = '0;
        exp_st = 2 + rdy + int'(TB_TIMEOUT);
      end else begin
        r.rdata = wr ? 32'd0 : load_val(f3, off, rdata);
        exp_st = 3 + rdy + ack;
      end
    end
    exp_rsp.push_back(r);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!mem_stall) break;
      st++;
    end
    check("stall_cycles", st, exp_st);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    req_read = 1'b0;
    req_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic reset_mid(input int rdy, input int cycles, input bit in_req);
    breq_t b;
    @(posedge clk);
    #1;
    cfg_rdy_dly = rdy;
    cfg_ack_dly = 100000;
    cfg_spur    = 0;
    req_read    = 1'b1;
    req_write   = 1'b0;
    req_funct3  = 3'd2;
    req_addr    = 32'h0000_0300;
    req_wdata   = '0;
    b.addr = 32'h0000_0300;
    b.we = 0;
    b.be = 4'hF;
    b.wdata = '0;
    b.chk_be = 1;
    b.chk_wdata = 0;
    exp_bus.push_back(b);
    repeat (cycles) @(negedge clk);
    check("stall_before_reset", {31'd0, mem_stall}, 32'd1);
    check("bus_valid_before_reset", {31'd0, bus_valid}, {31'd0, in_req});
    #2;
    rst = 1'b0;
    req_read = 1'b0;
    #1;
    check("bus_valid_async_reset", {31'd0, bus_valid}, 32'd0);
    check("stall_async_reset", {31'd0, mem_stall}, 32'd0);
    check("rsp_rdata_async_reset", rsp_rdata, 32'd0);
    exp_bus.delete();
    exp_rsp.delete();
    exp_hold = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          op;
    bit          rd, wr;
    logic [31:0] a;
    rst        = 1'b1;
    req_read   = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    rst = 1'b1;

    // Directed cases
    access(1, 0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    access(1, 0, 3'd0, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0, 0);
    access(1, 0, 3'd4, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0, 0);
    access(1, 0, 3'd1, 32'h0000_0102, 32'h0, 32'h8011_2233, 0, 0, 0);
    access(0, 1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 32'h5555_AAAA, 0, 0, 0);
    access(0, 1, 3'd1, 32'h0000_0202, 32'hFFFF_1234, 32'h5555_AAAA, 0, 0, 0);
    access(1, 0, 3'd2, 32'h0000_0102, 32'h0, 32'h1111_1111, 0, 0, 0);
    access(1, 0, 3'd2, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 2, 3, 1);
    access(1, 1, 3'd2, 32'h0000_0208, 32'hCAFE_F00D, 32'h7777_7777, 1, 0, 1);
    access(1, 0, 3'd5, 32'h0000_0112, 32'h0, 32'hF00D_8001, 0, 1, 0);
    access(1, 0, 3'd2, 32'h0000_0120, 32'h0, 32'h0123_4567, 0, int'(TB_TIMEOUT) - 1, 0);
`ifdef MEM_BUS_TIMEOUT_EN
    access(1, 0, 3'd2, 32'h0000_0124, 32'h0, 32'h89AB_CDEF, 1, 100000, 0);
`else
    access(1, 0, 3'd2, 32'h0000_0124, 32'h0, 32'h89AB_CDEF, 1, 20, 0);
`endif
    access(1, 0, 3'd0, 32'h0000_0131, 32'h0, 32'h0000_7F00, 0, 0, 0);

    // Resets in REQ and in WAIT, then a stale ack while idle
    reset_mid(100000, 2, 1);
    reset_mid(0, 4, 0);
    cfg_stale = 1;
    idle(3);
    access(1, 0, 3'd2, 32'h0000_0400, 32'h0, 32'hA5A5_5A5A, 0, 0, 0);

    // Randomized back-to-back accesses
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      rd = (op != 1);
      wr = (op == 1) || (op == 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      access(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    check("rsp_queue_empty", exp_rsp.size(), 32'd0);
    check("bus_queue_empty", exp_bus.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Data-memory bus interface for the five-stage RISC-V pipeline, sitting directly downstream of the MEM stage. It converts the MEM stage's load/store request (address, store data, funct3) into a single-outstanding valid/ready transaction on an external memory bus. It holds the pipeline with `mem_stall` until the access completes, and returns aligned, sign- or zero-extended load data.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the access is forced to complete with an error (range 1–255).
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset. Asynchronous, active-low.
- `req_read` in 1: MEM-stage load request. Held stable while `mem_stall`=1.
- `req_write` in 1: MEM-stage store request. Held stable while `mem_stall`=1.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data in the low bits.
- `req_funct3` in 3: RISC-V funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other value is treated as word.
- `mem_stall` out 1: pipeline hold, combinational.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data.
- `misalign` out 1: one-cycle pulse when a misaligned access is rejected.
- `bus_err` out 1: one-cycle pulse with `rsp_valid` on a timed-out access.
- `bus_valid` out 1: request valid, registered.
- `bus_ready` in 1: bus accepts the request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address `{req_addr[31:2],2'b00}`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_be` out 4: byte enables.
- `bus_ack` in 1: completion strobe.
- `bus_rdata` in 32: read data, valid with `bus_ack`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Request detection:
  - `new_req = (req_read|req_write) && state==IDLE && !misaligned`.
  - If both `req_read` and `req_write` are set, write wins and the read is ignored.
- Misalignment rules:
  - Word access: `addr[1:0]!=0` is misaligned.
  - Half access: `addr[0]!=0` is misaligned.
  - Byte access is never misaligned.
  - A misaligned access in IDLE pulses `misalign` for one cycle, performs no bus access, and does not stall.
- IDLE → REQ on `new_req`. On that edge, latch `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, funct3 and `addr[1:0]`.
- REQ: `bus_valid`=1 and all bus outputs held stable. On `bus_valid&&bus_ready`, go to WAIT. `bus_ack` is ignored in REQ.
- WAIT:
  - On `bus_ack`: capture the extracted load data and go to DONE.
  - Timeout: if the counter reaches `TIMEOUT` without `bus_ack`, go to DONE with the error flag set and captured data forced to 0.
- DONE: `rsp_valid`=1 and `bus_err`=error flag, then unconditionally return to IDLE. Because request inputs are still asserted in DONE, request detection is suppressed there, so the access is never re-issued.
- `mem_stall` = `new_req | (state==REQ) | (state==WAIT)`. It is 0 in DONE so the pipeline advances on that edge.
- Store byte lanes:
  - SB: `be = 4'b0001<<addr[1:0]`, `wdata = {4{b}}`.
  - SH: `be = 4'b0011<<addr[1:0]`, `wdata = {2{h}}`.
  - SW: `be = 4'hF`.
- Load extraction: `sh = bus_rdata >> (8*addr[1:0])`.
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass-through.
- `rsp_rdata` holds its value until the next completion. It is 0 after stores.
- Any `bus_ack` received in IDLE, REQ or DONE is ignored.

## Timing
- Reset values: state IDLE; all registered outputs 0 (`bus_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `rsp_valid`, `rsp_rdata`, `bus_err`, `misalign`); timeout counter 0.
- Zero-wait bus (`bus_ready` in the first REQ cycle, `bus_ack` in the next cycle):
  - Cycle 0 IDLE: stall=1.
  - Cycle 1 REQ.
  - Cycle 2 WAIT: ack.
  - Cycle 3 DONE: stall=0, `rsp_valid`=1.
  - Result: 3 stall cycles; the instruction spends 4 cycles in MEM.
- Each cycle `bus_ready` is low in REQ adds one stall cycle. Each cycle without `bus_ack` in WAIT adds one stall cycle.
- Timeout counter:
  - Cleared on entry to WAIT; increments each WAIT cycle.
  - Timeout fires when count == `TIMEOUT`-1 and `bus_ack`=0.
  - If `bus_ack` arrives in the same cycle as the timeout, the ack wins and no error is flagged.
- Reset mid-access: `rst` low immediately clears `bus_valid` and state (asynchronous). The next request starts fresh.
- Back-to-back accesses: the second request is detected in the cycle after DONE (IDLE). Minimum spacing is 4 cycles.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined: the WAIT timeout counter and `bus_err` generation are compiled in.
- Not defined: no counter. WAIT exits only on `bus_ack`, `bus_err` is tied to 0, and `TIMEOUT` is unused.

## Test plan
- Zero-wait LW, `addr`=0x100, `bus_rdata`=0xDEADBEEF → `mem_stall` high for exactly 3 cycles; `bus_addr`=0x100, `bus_be`=0xF, `bus_we`=0; `rsp_valid` in cycle 3; `rsp_rdata`=0xDEADBEEF.
- LB `addr`=0x103 with `bus_rdata`=0x80112233 → `rsp_rdata`=0xFFFFFF80. Same access as LBU → 0x00000080. LH `addr`=0x102 → 0xFFFF8011.
- SB `addr`=0x201, `wdata`=0x000000AB → `bus_be`=0x2, `bus_wdata`=0xABABABAB, `bus_we`=1. SH `addr`=0x202 with `wdata` low half 0x1234 → `bus_be`=0xC, `bus_wdata`=0x12341234.
- LW `addr`=0x102 → `misalign` pulse, `mem_stall`=0, `bus_valid` never asserted.
- `bus_ready` delayed 2 cycles and `bus_ack` delayed 3 → 8 stall cycles. Spurious `bus_ack` in REQ is ignored. With `MEM_BUS_TIMEOUT_EN` and `TIMEOUT`=4 and no ack → `rsp_valid`+`bus_err` with `rsp_rdata`=0.
- `rst` low while in WAIT → `bus_valid`/state cleared asynchronously. After release, a new LW completes normally and a late stale `bus_ack` in IDLE has no effect.
